// File: rtl/hash_pkg.sv
// Shared definitions for the hash datapath: word geometry, the writeback
// state encoding and the per-word bit-reversal helper.
package hash_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int HASH_BITS  = 256;
  localparam int NUM_WORDS  = HASH_BITS / WORD_WIDTH;
  localparam int WSEL_W     = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The assembly stage stores each digest word bit-reversed; this undoes it.
  function automatic logic [WORD_WIDTH-1:0] bit_reverse32(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_WIDTH; b++) begin
      r[b] = w[WORD_WIDTH-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/hash_word_mux.sv
// Selects one 32-bit word out of a 256-bit digest and restores its bit order.
// Purely combinational; the caller registers the result.
module hash_word_mux
  import hash_pkg::*;
(
  input  logic [HASH_BITS-1:0]  vector,
  input  logic [WSEL_W-1:0]     index,
  output logic [WORD_WIDTH-1:0] word
);

  logic [WORD_WIDTH-1:0] words [NUM_WORDS];

  // Slice the flat digest into addressable words.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slice
      assign words[gi] = vector[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // Pick the requested word and flip it back to natural bit order.
  always_comb begin
    word = bit_reverse32(words[index]);
  end

endmodule

// File: rtl/hash_writeback.sv
// Writes a captured 256-bit digest to the output SRAM, one 32-bit word per
// accepted cycle, then pulses done for one cycle.
// Optional build macro HASH_WB_CHECKSUM_EN adds wb_checksum, the XOR of all
// accepted write words of the current message.
module hash_writeback
  import hash_pkg::*;
#(
  parameter int HASH_LENGTH = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hash_vector_complete,
  input  logic [HASH_BITS-1:0]  hash_vector,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic                  out_stall,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  out_write_en,
  output logic [WORD_WIDTH-1:0] out_write_data,
  output logic                  busy,
  output logic                  done
`ifdef HASH_WB_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0] wb_checksum
`endif
);

  localparam logic [WSEL_W-1:0] LAST_IDX = WSEL_W'(HASH_LENGTH - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic                    complete_prev_reg;
  logic [HASH_BITS-1:0]    cap_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [WSEL_W-1:0]       counter_reg;
  logic [ADDR_WIDTH-1:0]   address_reg;
  logic                    write_en_reg;
  logic [WORD_WIDTH-1:0]   write_data_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic                    start_edge;
  logic                    accept;
  logic                    last_word;
  logic [HASH_BITS-1:0]    mux_vector;
  logic [WSEL_W-1:0]       mux_index;
  logic [WORD_WIDTH-1:0]   mux_word;

  assign start_edge = hash_vector_complete && !complete_prev_reg;
  assign accept     = write_en_reg && !out_stall;
  assign last_word  = (counter_reg == LAST_IDX);

  // Next-state logic: a start edge only counts in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = WRITE;
      WRITE:   if (accept && last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the first word comes straight from the input so it can be
  // presented the cycle after the start edge; afterwards the capture feeds
  // the word following the one currently on the bus.
  always_comb begin
    mux_vector = cap_reg;
    mux_index  = counter_reg + 1'b1;
    if (state_reg == IDLE) begin
      mux_vector = hash_vector;
      mux_index  = '0;
    end
  end

  hash_word_mux u_word_mux (
    .vector (mux_vector),
    .index  (mux_index),
    .word   (mux_word)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture, word counter and registered SRAM interface; a stall freezes the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      complete_prev_reg <= 1'b0;
      cap_reg           <= '0;
      base_reg          <= '0;
      counter_reg       <= '0;
      address_reg       <= '0;
      write_en_reg      <= 1'b0;
      write_data_reg    <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      complete_prev_reg <= hash_vector_complete;
      done_reg          <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            cap_reg        <= hash_vector;
            base_reg       <= base_address;
            counter_reg    <= '0;
            busy_reg       <= 1'b1;
            write_en_reg   <= 1'b1;
            address_reg    <= base_address;
            write_data_reg <= mux_word;
          end
        end
        WRITE: begin
          if (accept) begin
            if (last_word) begin
              write_en_reg <= 1'b0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              counter_reg    <= mux_index;
              address_reg    <= base_reg + ADDR_WIDTH'(mux_index);
              write_data_reg <= mux_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_address    = address_reg;
  assign out_write_en   = write_en_reg;
  assign out_write_data = write_data_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

`ifdef HASH_WB_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_reg;

  // Running XOR of accepted words; restarts with each new message.
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && start_edge) begin
      checksum_reg <= '0;
    end else if (state_reg == WRITE && accept) begin
      checksum_reg <= checksum_reg ^ write_data_reg;
    end
  end

  assign wb_checksum = checksum_reg;
`endif

endmodule
